// File: rtl/ah_snoop_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ah_snoop_fifo_pkg
// Shared constants and helpers for the parametrised snoopable FIFO:
//   - default geometry (data width, depth, key field position/width)
//   - ptr_w / cnt_w : index and occupancy-counter widths from a depth
//   - key_t         : the entry key slice at default geometry
// ---------------------------------------------------------------------------
package ah_snoop_fifo_pkg;

  localparam int DEF_DW      = 164;
  localparam int DEF_DEPTH   = 48;
  localparam int DEF_KEY_LSB = 0;
  localparam int DEF_KEY_W   = 3;

  // Index width for slots 0..depth-1; at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [DEF_KEY_W-1:0] key_t;

endpackage

// File: rtl/ah_snoop_fifo_match.sv
// ---------------------------------------------------------------------------
// ah_snoop_fifo_match
// Purely combinational DEPTH-way key compare with popcount.
// Ports:
//   i_keys  : key field of every slot, slot j at [j*KEY_W +: KEY_W]
//   i_mask  : slots eligible to match (occupied and, if enabled, live)
//   i_skey  : snoop key
//   o_hit   : per-slot hit vector
//   o_cnt   : number of set bits in o_hit
// ---------------------------------------------------------------------------
module ah_snoop_fifo_match #(
  parameter int DEPTH = 48,
  parameter int KEY_W = 3,
  parameter int CW    = 6
) (
  input  logic [DEPTH*KEY_W-1:0] i_keys,
  input  logic [DEPTH-1:0]       i_mask,
  input  logic [KEY_W-1:0]       i_skey,
  output logic [DEPTH-1:0]       o_hit,
  output logic [CW-1:0]          o_cnt
);

  logic [DEPTH-1:0] w_hit;
  logic [CW-1:0]    w_cnt;

  always_comb begin
    w_hit = '0;
    w_cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_hit[j] = i_mask[j] && (i_keys[j*KEY_W +: KEY_W] == i_skey);
      w_cnt    = w_cnt + CW'(w_hit[j]);
    end
  end

  assign o_hit = w_hit;
  assign o_cnt = w_cnt;

endmodule

// File: rtl/ah_snoop_fifo_param.sv
// ---------------------------------------------------------------------------
// ah_snoop_fifo_param
// Valid/ready FIFO of DEPTH x DW entries (any DEPTH >= 2) with a snoop port
// that counts occupied entries whose key field matches skey. Snoop results
// are registered and appear the cycle after svalid.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   wdata/wvalid/wready: write side
//   rdata/rvalid/rready: read side (rdata is a combinational head mux)
//   skey/svalid        : snoop request
//   smatch/smatch_cnt  : registered snoop hit flag / hit count
//   count              : current occupancy
// Optional build macro AH_SNOOP_FIFO_KILL_EN adds input skill: a snoop with
// skill set clears a live bit on every matching entry; dead head entries are
// popped automatically (rvalid held low) and never match again.
// ---------------------------------------------------------------------------
module ah_snoop_fifo_param
  import ah_snoop_fifo_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int KEY_LSB = DEF_KEY_LSB,
  parameter int KEY_W   = DEF_KEY_W
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DW-1:0]             wdata,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [DW-1:0]             rdata,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [KEY_W-1:0]          skey,
  input  logic                      svalid,
`ifdef AH_SNOOP_FIFO_KILL_EN
  input  logic                      skill,
`endif
  output logic                      smatch,
  output logic [cnt_w(DEPTH)-1:0]   smatch_cnt,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0]          r_mem [DEPTH];
  logic [PW-1:0]          r_wr_idx;
  logic [PW-1:0]          r_rd_idx;
  logic [CW-1:0]          r_count;
  logic                   r_smatch;
  logic [CW-1:0]          r_smatch_cnt;

  logic [DEPTH-1:0]       w_live;
  logic [DEPTH-1:0]       w_occ;
  logic [DEPTH*KEY_W-1:0] w_keys;
  logic [DEPTH-1:0]       w_hit;
  logic [CW-1:0]          w_hit_cnt;
  logic                   w_nonempty;
  logic                   w_head_live;
  logic                   w_autopop;
  logic                   w_push;
  logic                   w_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(DEPTH - 1)) ? '0 : idx + PW'(1);
  endfunction

`ifdef AH_SNOOP_FIFO_KILL_EN
  logic [DEPTH-1:0] r_live;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_live <= '0;
    end else begin
      if (svalid && skill) r_live <= r_live & ~w_hit;
      // The pushed slot is never in the hit set (unoccupied pre-edge).
      if (w_push) r_live[r_wr_idx] <= 1'b1;
    end
  end

  assign w_live = r_live;
`else
  assign w_live = '1;
`endif

  assign w_nonempty  = (r_count != '0);
  assign w_head_live = w_live[r_rd_idx];
  assign w_autopop   = w_nonempty & ~w_head_live;

  assign wready = (r_count != CW'(DEPTH));
  assign rvalid = w_nonempty & w_head_live;
  assign rdata  = r_mem[r_rd_idx];
  assign count  = r_count;
  assign smatch     = r_smatch;
  assign smatch_cnt = r_smatch_cnt;

  assign w_push = wvalid & wready;
  assign w_pop  = (rvalid & rready) | w_autopop;

  // Slot j is occupied when its distance ahead of rd_idx (mod DEPTH) is
  // below count; count == DEPTH therefore marks every slot.
  always_comb begin
    w_occ  = '0;
    w_keys = '0;
    for (int j = 0; j < DEPTH; j++) begin
      int off;
      if (j >= int'(r_rd_idx)) off = j - int'(r_rd_idx);
      else                     off = j + DEPTH - int'(r_rd_idx);
      w_occ[j] = (off < int'(r_count));
      w_keys[j*KEY_W +: KEY_W] = r_mem[j][KEY_LSB +: KEY_W];
    end
  end

  ah_snoop_fifo_match #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W),
    .CW    (CW)
  ) u_match (
    .i_keys (w_keys),
    .i_mask (w_occ & w_live),
    .i_skey (skey),
    .o_hit  (w_hit),
    .o_cnt  (w_hit_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_idx <= next_idx(r_wr_idx);
      if (w_pop)  r_rd_idx <= next_idx(r_rd_idx);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Snoop result uses occupancy as it stood before this edge's push/pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_smatch     <= 1'b0;
      r_smatch_cnt <= '0;
    end else if (svalid) begin
      r_smatch     <= |w_hit;
      r_smatch_cnt <= w_hit_cnt;
    end else begin
      r_smatch     <= 1'b0;
      r_smatch_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ah_snoop_fifo_param.sv
module tb_ah_snoop_fifo_param;
  import ah_snoop_fifo_pkg::*;

  localparam int DW    = 164;
  localparam int DEPTH = 48;
  localparam int KEY_W = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rstn;
  logic [DW-1:0]   wdata;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            rready;
  key_t            skey;
  logic            svalid;
  logic            skill;
  logic            smatch;
  logic [CW-1:0]   smatch_cnt;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  ah_snoop_fifo_param #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .KEY_LSB (0),
    .KEY_W   (KEY_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .skey       (skey),
    .svalid     (svalid),
`ifdef AH_SNOOP_FIFO_KILL_EN
    .skill      (skill),
`endif
    .smatch     (smatch),
    .smatch_cnt (smatch_cnt),
    .count      (count)
  );

  // Reference model: an ordered list of entries, each with a live flag.
  typedef struct {
    logic [DW-1:0] d;
    bit            live;
  } ent_t;

  ent_t q[$];
  int   exp_hits;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic bit exp_rvalid();
    if (q.size() == 0) return 1'b0;
    return q[0].live;
  endfunction

  task automatic check_outputs();
    chk("count", DW'(count), DW'(q.size()));
    chk("wready", DW'(wready), DW'(q.size() != DEPTH));
    chk("rvalid", DW'(rvalid), DW'(exp_rvalid()));
    if (exp_rvalid()) chk("rdata", rdata, q[0].d);
    chk("smatch", DW'(smatch), DW'(exp_hits != 0));
    chk("smatch_cnt", DW'(smatch_cnt), DW'(exp_hits));
  endtask

  // One clock edge: model the edge from the pre-edge inputs, then compare.
  task automatic step();
    int            sz;
    bit            pu;
    bit            po;
    int            hits;
    logic [DW-1:0] wd;
    ent_t          e;
    sz   = q.size();
    po   = (exp_rvalid() && rready) || (sz != 0 && !q[0].live);
    pu   = wvalid && (sz != DEPTH);
    wd   = wdata;
    hits = 0;
    if (svalid) begin
      foreach (q[i]) begin
        if (q[i].live && q[i].d[KEY_W-1:0] == skey) begin
          hits++;
          if (skill) q[i].live = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (po) void'(q.pop_front());
    if (pu) begin
      e.d    = wd;
      e.live = 1'b1;
      q.push_back(e);
    end
    exp_hits = hits;
    check_outputs();
  endtask

  task automatic idle();
    wvalid = 1'b0;
    rready = 1'b0;
    svalid = 1'b0;
    skill  = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    chk("rst_count", DW'(count), '0);
    chk("rst_rvalid", DW'(rvalid), '0);
    chk("rst_wready", DW'(wready), DW'(1));
    chk("rst_smatch", DW'(smatch), '0);
    chk("rst_smatch_cnt", DW'(smatch_cnt), '0);
    chk("rst_rdata", rdata, '0);
    q.delete();
    exp_hits = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    idle();
    rready = 1'b1;
    for (int k = 0; k < DEPTH + 4 && q.size() != 0; k++) step();
    rready = 1'b0;
    chk("drain_count", DW'(count), '0);
  endtask

  function automatic logic [DW-1:0] keyed(input int key, input int tag);
    logic [DW-1:0] d;
    d = rnd_data();
    d[KEY_W-1:0] = KEY_W'(key);
    d[KEY_W+15:KEY_W] = 16'(tag);
    return d;
  endfunction

  initial begin
    rstn  = 1'b0;
    wdata = '0;
    skey  = '0;
    exp_hits = 0;
    idle();
    #3;
    do_reset();

    // Idle after reset
    for (int k = 0; k < 3; k++) step();
    chk("idle_rdata", rdata, '0);

    // Fill to DEPTH with wdata = i, then one dropped write
    wvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata = DW'(i);
      step();
    end
    chk("full_wready", DW'(wready), '0);
    wdata = DW'(999);
    step();
    chk("full_count", DW'(count), DW'(DEPTH));
    wvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("readback", rdata, DW'(i));
      step();
    end
    chk("empty_count", DW'(count), '0);
    chk("empty_rvalid", DW'(rvalid), '0);
    rready = 1'b0;

    // Fill, then simultaneous push/pop for 100 cycles across the wrap
    wvalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata = DW'(1000 + i);
      step();
    end
    rready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wdata = DW'(2000 + i);
      step();
    end
    drain();

    // Keys 5,5,2 then snoop 5 and 7
    wvalid = 1'b1;
    wdata = keyed(5, 1); step();
    wdata = keyed(5, 2); step();
    wdata = keyed(2, 3); step();
    wvalid = 1'b0;
    svalid = 1'b1;
    skey = 3'd5; step();
    chk("snoop5_match", DW'(smatch), DW'(1));
    chk("snoop5_cnt", DW'(smatch_cnt), DW'(2));
    skey = 3'd7; step();
    chk("snoop7_match", DW'(smatch), '0);
    chk("snoop7_cnt", DW'(smatch_cnt), '0);
    svalid = 1'b0;
    step();
    chk("snoop_clear", DW'(smatch_cnt), '0);
    drain();

    // Same-edge push excluded, same-edge pop included
    wvalid = 1'b1; wdata = keyed(6, 4);
    svalid = 1'b1; skey = 3'd6;
    step();
    chk("push_excl", DW'(smatch), '0);
    svalid = 1'b0;
    wdata = keyed(3, 5); step();
    wvalid = 1'b0;
    rready = 1'b1; step();
    svalid = 1'b1; skey = 3'd3;
    step();
    chk("pop_incl", DW'(smatch), DW'(1));
    chk("pop_incl_cnt", DW'(smatch_cnt), DW'(1));
    drain();

    // Randomized traffic, biased towards filling then towards draining
    for (int i = 0; i < 1600; i++) begin
      if (i < 800) begin
        wvalid = ($urandom_range(0, 3) != 0);
        rready = ($urandom_range(0, 2) == 0);
      end else begin
        wvalid = ($urandom_range(0, 2) == 0);
        rready = ($urandom_range(0, 3) != 0);
      end
      wdata  = rnd_data();
      svalid = $urandom_range(0, 1) == 1;
      skey   = KEY_W'($urandom_range(0, 7));
`ifdef AH_SNOOP_FIFO_KILL_EN
      skill  = ($urandom_range(0, 15) == 0);
`endif
      step();
    end

    // Reset mid-operation with contents present
    idle();
    wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = rnd_data();
      step();
    end
    svalid = 1'b1; skey = q[0].d[KEY_W-1:0];
    step();
    idle();
    do_reset();
    step();

`ifdef AH_SNOOP_FIFO_KILL_EN
    // Kill keys 1 of 1,4,1: only the key-4 entry is ever read
    begin
      int reads;
      logic [DW-1:0] first_read;
      reads = 0;
      first_read = '0;
      wvalid = 1'b1;
      wdata = keyed(1, 10); step();
      wdata = keyed(4, 11); step();
      wdata = keyed(1, 12); step();
      wvalid = 1'b0;
      svalid = 1'b1; skill = 1'b1; skey = 3'd1;
      step();
      chk("kill_cnt", DW'(smatch_cnt), DW'(2));
      svalid = 1'b0; skill = 1'b0;
      rready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (rvalid) begin
          reads++;
          first_read = rdata;
        end
        step();
      end
      chk("kill_reads", DW'(reads), DW'(1));
      chk("kill_key", DW'(first_read[KEY_W-1:0]), DW'(4));
      chk("kill_count", DW'(count), '0);
      idle();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
